// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared pipeline widths, the $0 index and stage control bundle
package ex_mem_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W = 5;
    localparam int CNT_W = 16;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;
endpackage

// File: rtl/ex_mem_fwd_cmp.sv
// ex_mem_fwd_cmp: forwarding and load-use compare of a later-stage destination against EX sources
module ex_mem_fwd_cmp
    import ex_mem_pkg::*;
(
    input  logic             valid,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             load_use
);
    logic live;

    always_comb begin
        live     = valid && (rd != REG_ZERO);
        fwd_a    = live && reg_write && !mem_read && (rd == rs);
        fwd_b    = live && reg_write && !mem_read && (rd == rt);
        load_use = live && mem_read && ((rd == rs) || (rd == rt));
    end
endmodule

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register with stall/flush, instruction counter and MEM-stage hazard detect
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] EX_alu_result,
    input  logic [DATA_W-1:0] EX_rt_data,
    input  logic [REG_W-1:0]  EX_rd_mux,
    input  logic              EX_reg_write,
    input  logic              EX_mem_read,
    input  logic              EX_mem_write,
    input  logic              EX_mem_to_reg,
    input  logic              EX_valid,
    input  logic [REG_W-1:0]  EX_rs,
    input  logic [REG_W-1:0]  EX_rt,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] MEM_alu_result,
    output logic [DATA_W-1:0] MEM_rt_data,
    output logic [REG_W-1:0]  MEM_rd,
    output logic              MEM_reg_write,
    output logic              MEM_mem_read,
    output logic              MEM_mem_write,
    output logic              MEM_mem_to_reg,
    output logic              MEM_valid,
    output logic              fwd_a_mem,
    output logic              fwd_b_mem,
    output logic              load_use,
    output logic [CNT_W-1:0]  MEM_count
);
    logic [DATA_W-1:0] alu_q, alu_d, rt_q, rt_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  count_q, count_d;
    ctrl_t             ctrl_q, ctrl_d;

    // Flush clears control only; datapath and rd stay put so a bubble is cheap.
    always_comb begin
        alu_d   = alu_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        count_d = count_q;
        if (flush) begin
            ctrl_d = '0;
        end else if (!stall) begin
            alu_d            = EX_alu_result;
            rt_d             = EX_rt_data;
            rd_d             = EX_rd_mux;
            ctrl_d.valid     = EX_valid;
            ctrl_d.reg_write = EX_valid && EX_reg_write && (EX_rd_mux != REG_ZERO);
            ctrl_d.mem_read  = EX_valid && EX_mem_read;
            ctrl_d.mem_write = EX_valid && EX_mem_write;
            ctrl_d.mem_to_reg = EX_valid && EX_mem_to_reg;
            count_d          = count_q + CNT_W'(EX_valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q   <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            count_q <= '0;
        end else begin
            alu_q   <= alu_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
        end
    end

    assign MEM_alu_result = alu_q;
    assign MEM_rt_data    = rt_q;
    assign MEM_rd         = rd_q;
    assign MEM_reg_write  = ctrl_q.reg_write;
    assign MEM_mem_read   = ctrl_q.mem_read;
    assign MEM_mem_write  = ctrl_q.mem_write;
    assign MEM_mem_to_reg = ctrl_q.mem_to_reg;
    assign MEM_valid      = ctrl_q.valid;
    assign MEM_count      = count_q;

    ex_mem_fwd_cmp u_fwd_cmp (
        .valid     (ctrl_q.valid),
        .reg_write (ctrl_q.reg_write),
        .mem_read  (ctrl_q.mem_read),
        .rd        (rd_q),
        .rs        (EX_rs),
        .rt        (EX_rt),
        .fwd_a     (fwd_a_mem),
        .fwd_b     (fwd_b_mem),
        .load_use  (load_use)
    );
endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: directed scoreboard bench for the EX/MEM pipeline register
module tb_ex_mem;
    logic        clk = 0;
    logic        rst_n;
    logic [31:0] ex_alu, ex_rtd;
    logic [4:0]  ex_rd, ex_rs, ex_rt;
    logic        ex_rw, ex_mr, ex_mw, ex_m2r, ex_v;
    logic        stall, flush;
    logic [31:0] mem_alu, mem_rtd;
    logic [4:0]  mem_rd;
    logic        mem_rw, mem_mr, mem_mw, mem_m2r, mem_v;
    logic        fwd_a, fwd_b, lu;
    logic [15:0] mem_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] alu, rtd;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r, v, dk;
        logic [15:0] cnt;
    } exp_t;

    exp_t m;
    exp_t sb[$];

    always #5 clk = ~clk;

    ex_mem dut (
        .clk(clk), .rst_n(rst_n),
        .EX_alu_result(ex_alu), .EX_rt_data(ex_rtd), .EX_rd_mux(ex_rd),
        .EX_reg_write(ex_rw), .EX_mem_read(ex_mr), .EX_mem_write(ex_mw),
        .EX_mem_to_reg(ex_m2r), .EX_valid(ex_v), .EX_rs(ex_rs), .EX_rt(ex_rt),
        .stall(stall), .flush(flush),
        .MEM_alu_result(mem_alu), .MEM_rt_data(mem_rtd), .MEM_rd(mem_rd),
        .MEM_reg_write(mem_rw), .MEM_mem_read(mem_mr), .MEM_mem_write(mem_mw),
        .MEM_mem_to_reg(mem_m2r), .MEM_valid(mem_v),
        .fwd_a_mem(fwd_a), .fwd_b_mem(fwd_b), .load_use(lu), .MEM_count(mem_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] rtd, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic m2r,
                         input logic v, input logic [4:0] rs, input logic [4:0] rt);
        ex_alu = alu; ex_rtd = rtd; ex_rd = rd; ex_rw = rw; ex_mr = mr;
        ex_mw = mw; ex_m2r = m2r; ex_v = v; ex_rs = rs; ex_rt = rt;
    endtask

    task automatic model_reset();
        m = '{alu: 0, rtd: 0, rd: 0, rw: 0, mr: 0, mw: 0, m2r: 0, v: 0, dk: 1, cnt: 0};
    endtask

    task automatic chk_haz(input string tag);
        logic live, fa, fb, l;
        live = m.v && (m.rd != 0);
        fa = live && m.rw && !m.mr && (m.rd == ex_rs);
        fb = live && m.rw && !m.mr && (m.rd == ex_rt);
        l  = live && m.mr && ((m.rd == ex_rs) || (m.rd == ex_rt));
        chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(fa));
        chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(fb));
        chk({tag, ".load_use"}, 32'(lu), 32'(l));
    endtask

    // One clock: the model predicts the register contents, the scoreboard holds them until sampled.
    task automatic cyc(input string tag, input logic st, input logic fl, input logic do_chk);
        exp_t e;
        @(negedge clk);
        rst_n = 1; stall = st; flush = fl;
        if (fl) begin
            m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0;
        end else if (!st) begin
            m.alu = ex_alu; m.rtd = ex_rtd; m.rd = ex_rd; m.dk = ex_v;
            m.v = ex_v;
            m.rw = ex_v && ex_rw && (ex_rd != 0);
            m.mr = ex_v && ex_mr; m.mw = ex_v && ex_mw; m.m2r = ex_v && ex_m2r;
            m.cnt = m.cnt + 16'(ex_v);
        end
        if (do_chk) sb.push_back(m);
        @(posedge clk);
        #1;
        if (do_chk) begin
            e = sb.pop_front();
            chk({tag, ".valid"}, 32'(mem_v), 32'(e.v));
            chk({tag, ".reg_write"}, 32'(mem_rw), 32'(e.rw));
            chk({tag, ".mem_read"}, 32'(mem_mr), 32'(e.mr));
            chk({tag, ".mem_write"}, 32'(mem_mw), 32'(e.mw));
            chk({tag, ".mem_to_reg"}, 32'(mem_m2r), 32'(e.m2r));
            chk({tag, ".count"}, 32'(mem_cnt), 32'(e.cnt));
            if (e.dk) begin
                chk({tag, ".alu"}, mem_alu, e.alu);
                chk({tag, ".rt_data"}, mem_rtd, e.rtd);
                chk({tag, ".rd"}, 32'(mem_rd), 32'(e.rd));
            end
            chk_haz(tag);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".alu"}, mem_alu, 0);
        chk({tag, ".rt_data"}, mem_rtd, 0);
        chk({tag, ".rd"}, 32'(mem_rd), 0);
        chk({tag, ".ctrl"}, {27'd0, mem_rw, mem_mr, mem_mw, mem_m2r, mem_v}, 0);
        chk({tag, ".count"}, 32'(mem_cnt), 0);
        chk({tag, ".haz"}, {29'd0, fwd_a, fwd_b, lu}, 0);
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_all_zero("por");

        drive(32'hAAAA_5555, 32'h1111_2222, 5'd3, 1, 0, 1, 1, 1, 5'd3, 5'd4);
        cyc("first_load", 0, 0, 1);

        // asynchronous reset mid-cycle while MEM_valid=1, with stall and flush asserted
        @(posedge clk);
        #2;
        chk("pre_reset.valid", 32'(mem_v), 1);
        rst_n = 0; stall = 1; flush = 1;
        #1 chk_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1 chk_all_zero("reset_held");
        stall = 0; flush = 0;
        drive(32'h0000_1234, 32'hDEAD_BEEF, 5'd5, 1, 0, 0, 0, 1, 5'd1, 5'd2);
        cyc("post_reset", 0, 0, 1);
        chk("post_reset.alu_exact", mem_alu, 32'h0000_1234);
        chk("post_reset.rd_exact", 32'(mem_rd), 5);
        chk("post_reset.count_exact", 32'(mem_cnt), 1);

        drive(32'h0BAD_F00D, 32'h0, 5'd7, 0, 1, 0, 1, 1, 5'd5, 5'd6);
        for (int i = 0; i < 3; i++) cyc("stall", 1, 0, 1);
        chk("stall.count_exact", 32'(mem_cnt), 1);
        chk("stall.alu_exact", mem_alu, 32'h0000_1234);

        cyc("stall_flush", 1, 1, 1);
        chk("stall_flush.valid", 32'(mem_v), 0);
        chk("stall_flush.rd_held", 32'(mem_rd), 5);

        drive(32'h2, 32'h3, 5'd9, 1, 0, 1, 0, 1, 5'd9, 5'd0);
        cyc("load2", 0, 0, 1);
        cyc("flush_only", 0, 1, 1);

        drive(32'h77, 32'h88, 5'd0, 1, 0, 0, 0, 1, 5'd0, 5'd0);
        cyc("rd_zero", 0, 0, 1);
        chk("rd_zero.reg_write", 32'(mem_rw), 0);
        chk("rd_zero.fwd_a", 32'(fwd_a), 0);

        drive(32'h100, 32'h200, 5'd8, 1, 0, 0, 0, 1, 5'd1, 5'd2);
        cyc("fwd_load", 0, 0, 1);
        drive(32'h0, 32'h0, 5'd1, 0, 0, 0, 0, 1, 5'd8, 5'd9);
        #1 chk("fwd.fwd_a", 32'(fwd_a), 1);
        chk("fwd.fwd_b", 32'(fwd_b), 0);
        chk("fwd.load_use", 32'(lu), 0);
        ex_rs = 5'd9; ex_rt = 5'd8;
        #1 chk("fwd_swap.fwd_a", 32'(fwd_a), 0);
        chk("fwd_swap.fwd_b", 32'(fwd_b), 1);

        drive(32'h300, 32'h400, 5'd8, 1, 1, 0, 1, 1, 5'd1, 5'd2);
        cyc("lw_load", 0, 0, 1);
        drive(32'h0, 32'h0, 5'd1, 0, 0, 0, 0, 1, 5'd8, 5'd9);
        #1 chk("lu.load_use", 32'(lu), 1);
        chk("lu.fwd_a", 32'(fwd_a), 0);
        ex_rs = 5'd3; ex_rt = 5'd8;
        #1 chk("lu_rt.load_use", 32'(lu), 1);
        chk("lu_rt.fwd_b", 32'(fwd_b), 0);

        drive(32'h5, 32'h6, 5'd12, 1, 0, 0, 0, 0, 5'd12, 5'd12);
        cyc("bubble", 0, 0, 1);

        drive(32'h1, 32'h2, 5'd4, 1, 0, 0, 0, 1, 5'd4, 5'd0);
        while (m.cnt != 16'hFFFE) cyc("bulk", 0, 0, 0);
        cyc("cnt_ffff", 0, 0, 1);
        chk("cnt_ffff.exact", 32'(mem_cnt), 32'h0000_FFFF);
        cyc("cnt_wrap", 0, 0, 1);
        chk("cnt_wrap.exact", 32'(mem_cnt), 0);
        ex_v = 0;
        cyc("cnt_bubble", 0, 0, 1);
        chk("cnt_bubble.exact", 32'(mem_cnt), 0);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 Parameter: DATA_W, default 32, datapath width of the ALU result and store data.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: EX_alu_result  input  DATA_W  ALU result from EX.
REQ-005 Port: EX_rt_data  input  DATA_W  store data from EX.
REQ-006 Port: EX_rd_mux  input  5  destination register chosen by the EX rd/rt mux.
REQ-007 Port: EX_reg_write, EX_mem_read, EX_mem_write, EX_mem_to_reg  input  1 each  EX control bits.
REQ-008 Port: EX_valid  input  1  EX holds a real instruction, not a bubble.
REQ-009 Port: EX_rs, EX_rt  input  5 each  source registers of the instruction currently in EX.
REQ-010 Port: stall  input  1  hold the register contents.
REQ-011 Port: flush  input  1  insert a bubble.
REQ-012 Port: MEM_alu_result, MEM_rt_data  output  DATA_W each  registered datapath.
REQ-013 Port: MEM_rd  output  5  registered destination register.
REQ-014 Port: MEM_reg_write, MEM_mem_read, MEM_mem_write, MEM_mem_to_reg, MEM_valid  output  1 each  registered control bits.
REQ-015 Port: fwd_a_mem, fwd_b_mem  output  1 each  forward MEM_alu_result to the EX rs/rt operand.
REQ-016 Port: load_use  output  1  a MEM-stage load targets an EX source; EX must stall.
REQ-017 Port: MEM_count  output  16  count of valid instructions that have entered MEM.

Function
REQ-018 Update order at each rising clk edge: flush, then stall, then load; flush has priority over stall.
REQ-019 Load: every MEM_* register captures its EX_* counterpart, with a latency of 1 cycle.
REQ-020 Load with EX_rd_mux==0: MEM_reg_write is captured as 0, because $0 is never written.
REQ-021 Load with EX_valid==0: all MEM control bits and MEM_valid are captured as 0; datapath registers are don't-care.
REQ-022 Stall without flush: every register, including MEM_count, holds its value.
REQ-023 Flush, with or without stall: MEM_valid and all MEM control bits are cleared to 0, and MEM_alu_result, MEM_rt_data and MEM_rd hold their values.
REQ-024 MEM_count increments by 1 only on a load edge with EX_valid==1, and wraps from 0xFFFF to 0x0000.
REQ-025 fwd_a_mem = MEM_valid & MEM_reg_write & ~MEM_mem_read & (MEM_rd!=0) & (MEM_rd==EX_rs); it is combinational from registers and inputs.
REQ-026 fwd_b_mem uses the same rule as REQ-025 with EX_rt in place of EX_rs.
REQ-027 load_use = MEM_valid & MEM_mem_read & (MEM_rd!=0) & ((MEM_rd==EX_rs) | (MEM_rd==EX_rt)); it is combinational.
REQ-028 fwd_* and load_use are never both asserted for the same operand.
REQ-029 No output depends combinationally on stall or flush.

Reset
REQ-030 While rst_n==0, all MEM_* outputs and MEM_count are 0 immediately, without waiting for a clock edge.
REQ-031 Reset during a stall or flush overrides both; the first edge after release performs a normal load, flush or stall.
REQ-032 During reset, fwd_a_mem, fwd_b_mem and load_use evaluate to 0.

Structure
REQ-033 Register-number width (5), the $0 index and DATA_W's default belong in the shared pipeline package/include, together with the other stage registers.
REQ-034 The hazard-compare logic (REQ-025..027) is one sub-module, ex_mem_fwd_cmp, which is reused by the MEM/WB forwarding path.
REQ-035 A single always block implements the registers; no latches.

Verification
REQ-036 Reset: drive rst_n=0 mid-cycle with MEM_valid=1 -> all outputs are 0 before the next edge; after release, load EX_alu_result=0x0000_1234, EX_rd_mux=5 -> after 1 cycle MEM_alu_result=0x1234, MEM_rd=5, MEM_count=1.
REQ-037 Stall/flush: stall=1 for 3 cycles -> outputs and MEM_count are unchanged; stall=1 and flush=1 together -> MEM_valid=0, MEM_reg_write=0, MEM_rd is held.
REQ-038 $0: load EX_rd_mux=0 with EX_reg_write=1 -> MEM_reg_write=0; with EX_rs=0 in EX, fwd_a_mem=0.
REQ-039 Forward and load-use: MEM_rd=8, MEM_reg_write=1, EX_rs=8, EX_rt=9 -> fwd_a_mem=1, fwd_b_mem=0; with MEM_mem_read=1 -> load_use=1 and fwd_a_mem=0.
REQ-040 Counter wrap: preload MEM_count to 0xFFFF via 65535 valid loads (a forced start is acceptable), then one more valid load -> MEM_count=0x0000; a bubble load (EX_valid=0) -> MEM_count is unchanged.
